// File: rtl/dla_simulate_cfg.sv
`default_nettype none
// ============================================================================
// Module   : dla_simulate_cfg
// Purpose  : Diffusion-limited aggregation engine with runtime particle
//            count/colour, drawing stuck particles over an Avalon-MM master.
// Revision : 1.0
// ============================================================================
module dla_simulate_cfg #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          AVN_AW    = 19,
    parameter int          AVN_DW    = 16,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STEPS = 65535,
    parameter logic [15:0] SEED_X    = 16'habcd,
    parameter logic [15:0] SEED_Y    = 16'h1234
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  cfg_count_i,
    input  logic [AVN_DW-1:0] cfg_color_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  par_left_o,
    output logic [AVN_AW-1:0] avn_address_o,
    output logic              avn_write_o,
    output logic [AVN_DW-1:0] avn_writedata_o,
    input  logic              avn_waitrequest_i
);
    localparam int HW     = $clog2(H_RES);
    localparam int VW     = $clog2(V_RES);
    localparam int c_npix = H_RES * V_RES;
    localparam logic [HW-1:0] c_cx = HW'(H_RES / 2);
    localparam logic [VW-1:0] c_cy = VW'(V_RES / 2);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_SEED, S_SPAWN, S_SPCHK, S_CHECK, S_STEP, S_STICK, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_x_q, lfsr_x_d, lfsr_y_q, lfsr_y_d;
    logic [HW-1:0]     px_q, px_d;
    logic [VW-1:0]     py_q, py_d;
    logic [AVN_AW-1:0] clr_q, clr_d;
    logic [CNT_W-1:0]  step_q, step_d, par_q, par_d;
    logic [AVN_DW-1:0] color_q, color_d;
    logic [2:0]        nb_q, nb_d;
    logic              hit_q, hit_d;
    logic [AVN_AW-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [AVN_DW-1:0] data_q, data_d;

    logic              mem [c_npix];
    logic              rd_q;
    logic              ram_we, ram_wd, ram_re;
    logic [AVN_AW-1:0] ram_wa, ram_ra;

    logic [15:0]       lfsr_x_nx, lfsr_y_nx;
    logic [HW-1:0]     cand_x, nb_x, mv_x;
    logic [VW-1:0]     cand_y, nb_y, mv_y;
    logic              nb_ok, accept;
    logic [CNT_W-1:0]  step_inc;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hD008 : 16'h0000);
    endfunction

    function automatic logic [AVN_AW-1:0] pix(input logic [HW-1:0] x, input logic [VW-1:0] y);
        return AVN_AW'(y) * AVN_AW'(H_RES) + AVN_AW'(x);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_x_q <= SEED_X;
            lfsr_y_q <= SEED_Y;
            px_q     <= '0;
            py_q     <= '0;
            clr_q    <= '0;
            step_q   <= '0;
            par_q    <= '0;
            color_q  <= '0;
            nb_q     <= '0;
            hit_q    <= 1'b0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_x_q <= lfsr_x_d;
            lfsr_y_q <= lfsr_y_d;
            px_q     <= px_d;
            py_q     <= py_d;
            clr_q    <= clr_d;
            step_q   <= step_d;
            par_q    <= par_d;
            color_q  <= color_d;
            nb_q     <= nb_d;
            hit_q    <= hit_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
        end
    end

    // Pattern RAM; an idle read port returns 0 so skipped off-screen neighbours read as empty.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        rd_q <= ram_re ? mem[ram_ra] : 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        lfsr_x_d = lfsr_x_q;
        lfsr_y_d = lfsr_y_q;
        px_d     = px_q;
        py_d     = py_q;
        clr_d    = clr_q;
        step_d   = step_q;
        par_d    = par_q;
        color_d  = color_q;
        nb_d     = nb_q;
        hit_d    = hit_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        data_d   = data_q;
        ram_we   = 1'b0;
        ram_wd   = 1'b0;
        ram_wa   = pix(px_q, py_q);
        ram_re   = 1'b0;
        ram_ra   = pix(px_q, py_q);
        accept   = wr_q & ~avn_waitrequest_i;
        step_inc = step_q + CNT_W'(1);

        lfsr_x_nx = lfsr_next(lfsr_x_q);
        lfsr_y_nx = lfsr_next(lfsr_y_q);
        cand_x    = lfsr_x_nx[HW-1:0];
        cand_y    = lfsr_y_nx[VW-1:0];

        // Neighbour order N, S, E, W indexed by the CHECK phase counter.
        nb_x  = px_q;
        nb_y  = py_q;
        nb_ok = 1'b0;
        case (nb_q)
            3'd0: begin nb_y = py_q - VW'(1); nb_ok = (py_q != '0);              end
            3'd1: begin nb_y = py_q + VW'(1); nb_ok = (32'(py_q) < V_RES - 1);   end
            3'd2: begin nb_x = px_q + HW'(1); nb_ok = (32'(px_q) < H_RES - 1);   end
            3'd3: begin nb_x = px_q - HW'(1); nb_ok = (px_q != '0);              end
            default: ;
        endcase

        mv_x = px_q;
        mv_y = py_q;
        case (lfsr_x_q[1:0])
            2'd0:    if (32'(px_q) < H_RES - 1) mv_x = px_q + HW'(1);
            2'd1:    if (px_q != '0)            mv_x = px_q - HW'(1);
            2'd2:    if (32'(py_q) < V_RES - 1) mv_y = py_q + VW'(1);
            default: if (py_q != '0)            mv_y = py_q - VW'(1);
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    par_d   = cfg_count_i;
                    color_d = cfg_color_i;
                    clr_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = clr_q;
                    data_d = '0;
                end else if (accept) begin
                    ram_we = 1'b1;
                    ram_wa = clr_q;
                    if (clr_q == AVN_AW'(c_npix - 1)) begin
                        wr_d    = 1'b0;
                        state_d = S_SEED;
                    end else begin
                        clr_d  = clr_q + AVN_AW'(1);
                        addr_d = clr_q + AVN_AW'(1);
                    end
                end
            end
            S_SEED: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = pix(c_cx, c_cy);
                    data_d = color_q;
                    ram_we = 1'b1;
                    ram_wa = pix(c_cx, c_cy);
                    ram_wd = 1'b1;
                end else if (accept) begin
                    wr_d    = 1'b0;
                    state_d = (par_q == '0) ? S_DONE : S_SPAWN;
                end
            end
            S_SPAWN: begin
                lfsr_x_d = lfsr_x_nx;
                lfsr_y_d = lfsr_y_nx;
                if (32'(cand_x) < H_RES && 32'(cand_y) < V_RES) begin
                    px_d    = cand_x;
                    py_d    = cand_y;
                    ram_re  = 1'b1;
                    ram_ra  = pix(cand_x, cand_y);
                    step_d  = '0;
                    state_d = S_SPCHK;
                end
            end
            S_SPCHK: begin
                if (rd_q) begin
                    state_d = S_SPAWN;
                end else begin
                    nb_d    = '0;
                    hit_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (nb_q != 3'd4 && nb_ok) begin
                    ram_re = 1'b1;
                    ram_ra = pix(nb_x, nb_y);
                end
                if (nb_q != 3'd0) hit_d = hit_q | rd_q;
                if (nb_q == 3'd4) state_d = (hit_q | rd_q) ? S_STICK : S_STEP;
                else              nb_d    = nb_q + 3'd1;
            end
            S_STEP: begin
                px_d     = mv_x;
                py_d     = mv_y;
                lfsr_x_d = lfsr_x_nx;
                lfsr_y_d = lfsr_y_nx;
                step_d   = step_inc;
                if (step_inc == CNT_W'(MAX_STEPS)) begin
                    state_d = S_SPAWN;
                end else begin
                    nb_d    = '0;
                    hit_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_STICK: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = pix(px_q, py_q);
                    data_d = color_q;
                    ram_we = 1'b1;
                    ram_wd = 1'b1;
                end else if (accept) begin
                    wr_d = 1'b0;
                    if (par_q != '0) par_d = par_q - CNT_W'(1);
                    state_d = (par_q <= CNT_W'(1)) ? S_DONE : S_SPAWN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o          = (state_q == S_DONE);
    assign par_left_o      = par_q;
    assign avn_address_o   = addr_q;
    assign avn_write_o     = wr_q;
    assign avn_writedata_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_dla_simulate_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_dla_simulate_cfg
// Purpose  : Self-checking bench for dla_simulate_cfg on an 8x8 screen.
// Revision : 1.0
// ============================================================================
module tb_dla_simulate_cfg;
    localparam int H = 8, V = 8, AW = 6, DW = 16, CW = 16, MAXS = 12;
    localparam int NP = H * V;
    localparam int HB = $clog2(H), VB = $clog2(V);
    localparam int SEEDPIX = (V / 2) * H + H / 2;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, wreq = 1'b0;
    logic [CW-1:0] cfg_count = '0;
    logic [DW-1:0] cfg_color = '0;
    logic          busy, done, wr;
    logic [CW-1:0] par_left;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    dla_simulate_cfg #(
        .H_RES(H), .V_RES(V), .AVN_AW(AW), .AVN_DW(DW), .CNT_W(CW), .MAX_STEPS(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .cfg_count_i(cfg_count),
        .cfg_color_i(cfg_color), .busy_o(busy), .done_o(done), .par_left_o(par_left),
        .avn_address_o(addr), .avn_write_o(wr), .avn_writedata_o(wdata),
        .avn_waitrequest_i(wreq)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: whole run as an untimed algorithm
    typedef struct { int addr; int data; bit stick; bit last; } exp_t;
    exp_t        q[$];
    exp_t        e;
    logic [15:0] mx, my;
    bit          occ[NP];
    bit          dut_occ[NP];
    int          exp_busy, exp_done, exp_par;

    function automatic logic [15:0] lnext(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hD008 : 16'h0000);
    endfunction

    function automatic bit touches(input int x, input int y, input bit use_dut);
        bit r = 0;
        if (y > 0     && (use_dut ? dut_occ[(y-1)*H+x] : occ[(y-1)*H+x])) r = 1;
        if (y < V - 1 && (use_dut ? dut_occ[(y+1)*H+x] : occ[(y+1)*H+x])) r = 1;
        if (x < H - 1 && (use_dut ? dut_occ[y*H+x+1]   : occ[y*H+x+1]))   r = 1;
        if (x > 0     && (use_dut ? dut_occ[y*H+x-1]   : occ[y*H+x-1]))   r = 1;
        return r;
    endfunction

    task automatic gen_run(input int cnt, input int col);
        int left, x, y, steps, guard;
        bit stuck;
        for (int a = 0; a < NP; a++) begin
            occ[a] = 0;
            q.push_back('{a, 0, 1'b0, 1'b0});
        end
        occ[SEEDPIX] = 1;
        q.push_back('{SEEDPIX, col, 1'b0, cnt == 0});
        left  = cnt;
        guard = 0;
        while (left > 0 && guard < 100000) begin
            guard++;
            mx = lnext(mx);
            my = lnext(my);
            x  = int'(mx[HB-1:0]);
            y  = int'(my[VB-1:0]);
            if (x >= H || y >= V) continue;
            if (occ[y*H+x]) continue;
            steps = 0;
            stuck = 0;
            while (!stuck && steps < MAXS) begin
                if (touches(x, y, 1'b0)) begin
                    stuck = 1;
                end else begin
                    case (mx[1:0])
                        2'd0:    if (x < H - 1) x++;
                        2'd1:    if (x > 0)     x--;
                        2'd2:    if (y < V - 1) y++;
                        default: if (y > 0)     y--;
                    endcase
                    mx = lnext(mx);
                    my = lnext(my);
                    steps++;
                end
            end
            if (stuck) begin
                occ[y*H+x] = 1;
                left--;
                q.push_back('{y*H+x, col, 1'b1, left == 0});
            end
        end
    endtask

    // ---------------- compare process (samples on the falling edge)
    bit prev_stall = 0;
    int prev_addr = 0, prev_data = 0;
    int run_writes = 0, run_colour = 0, last_addr = 0, last_data = 0;

    always @(negedge clk) begin
        if (rst) begin
            mx = 16'habcd;
            my = 16'h1234;
            q.delete();
            exp_busy   = 0;
            exp_done   = 0;
            exp_par    = 0;
            prev_stall = 0;
        end else begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("par_left", par_left, exp_par);
            if (prev_stall) begin
                chk("stall_write_held", wr, 1);
                chk("stall_addr_held", addr, prev_addr);
                chk("stall_data_held", wdata, prev_data);
            end
            if (wr && !wreq) begin
                run_writes++;
                last_addr = int'(addr);
                last_data = int'(wdata);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write got addr=%0d data=%0h expected no write", addr, wdata);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", addr, e.addr);
                    chk("wr_data", wdata, e.data);
                    if (e.stick) exp_par--;
                    if (e.last) begin
                        exp_busy = 0;
                        exp_done = 1;
                    end
                end
                if (wdata == '0) begin
                    dut_occ[addr] = 0;
                end else begin
                    if (run_colour > 0)
                        chk("stuck_pixel_adjacent", touches(int'(addr) % H, int'(addr) / H, 1'b1), 1);
                    run_colour++;
                    dut_occ[addr] = 1;
                end
            end
            prev_stall = wr && wreq;
            prev_addr  = int'(addr);
            prev_data  = int'(wdata);
            if (start && exp_busy == 0) begin
                exp_busy   = 1;
                exp_done   = 0;
                exp_par    = int'(cfg_count);
                run_writes = 0;
                run_colour = 0;
                gen_run(int'(cfg_count), int'(cfg_color));
            end
        end
    end

    // ---------------- slave stall generator
    int wmode = 0, hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (wmode)
            1:       wreq = ($urandom_range(0, 3) == 0);
            2:       if (wr && wdata == '0 && addr == AW'(10) && hold_cnt < 5) begin
                         wreq = 1'b1;
                         hold_cnt++;
                     end else begin
                         wreq = 1'b0;
                     end
            default: wreq = 1'b0;
        endcase
    end

    task automatic pulse_start(input int cnt, input int col);
        @(posedge clk);
        #1;
        start     = 1'b1;
        cfg_count = CW'(cnt);
        cfg_color = DW'(col);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout got done=0 expected done=1 within %0d cycles", name, budget);
        end
        chk({name, "_queue_empty"}, q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_par_left"}, par_left, 0);
        chk({name, "_avn_write"}, wr, 0);
        chk({name, "_avn_address"}, addr, 0);
        chk({name, "_avn_writedata"}, wdata, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // zero particles: clear plus seed only
        pulse_start(0, 16'h00f0);
        wait_done("cnt0", 2000);
        chk("cnt0_write_count", run_writes, 65);
        chk("cnt0_seed_addr", last_addr, 36);
        chk("cnt0_seed_data", last_data, 16'h00f0);
        chk("cnt0_busy_after", busy, 0);
        chk("cnt0_par_left_after", par_left, 0);

        // three particles with a 5-cycle stall inside the clear sweep
        wmode = 2;
        pulse_start(3, 16'h1234);
        wait_done("cnt3", 12000);
        chk("cnt3_colour_writes", run_colour, 4);
        chk("cnt3_write_count", run_writes, 68);
        chk("cnt3_stall_cycles", hold_cnt, 5);

        // random stalls; extra start pulses while busy must be ignored
        wmode = 1;
        pulse_start(6, 16'hbeef);
        repeat (30) @(posedge clk);
        pulse_start(99, 16'h0001);
        repeat (150) @(posedge clk);
        #1;
        if (busy) begin
            start     = 1'b1;
            cfg_count = CW'(77);
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done("cnt6", 15000);
        chk("cnt6_colour_writes", run_colour, 7);

        pulse_start(10, 16'h0a0a);
        wait_done("cnt10", 20000);
        chk("cnt10_colour_writes", run_colour, 11);

        // reset in the middle of a walk, then a fresh run from address 0
        pulse_start(5, 16'h5555);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (run_writes >= 66) break;
        end
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        wmode = 0;
        pulse_start(2, 16'h7777);
        wait_done("rerun", 12000);
        chk("rerun_write_count", run_writes, 67);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
